tag_array_arb: RTL and testbench

Two-port controller and arbiter in front of a single-port 32x22 tag SRAM macro (registered inputs on posedge, read data on the following negedge). Shares the macro between a lookup requester (A, cache control read path) and a fill requester (B, miss/replace path) with round-robin arbitration. Returns read data one cycle after grant. Also clears the uninitialised macro after reset.

---
 rtl/tag_array_arb_if.sv | 21 ++
 rtl/tag_array_arb.sv | 72 +++++++
 tb/tb_tag_array_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tag_array_arb_if.sv
// tag_array_arb_if: lookup (A) and fill (B) requester handshake bundle plus ready for tag_array_arb
interface tag_array_arb_if #(
   parameter int DATA_WIDTH = 22,
   parameter int ADDR_WIDTH = 5
);
   logic                  ready;
   logic                  a_req, a_we, a_gnt, a_rvalid;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata, a_rdata;
   logic                  b_req, b_we, b_gnt, b_rvalid;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata, b_rdata;
   modport master (
      input  ready, a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata
   );
   modport slave (
      output ready, a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata
   );
endinterface

// File: rtl/tag_array_arb.sv
// tag_array_arb: round-robin arbiter and post-reset init sweeper in front of a single-port tag SRAM macro.
// Define TAG_ARB_INIT_SWEEP_EN to write INIT_VALUE to every entry after reset; otherwise ready rises one cycle after reset.
module tag_array_arb #(
   parameter int                    DATA_WIDTH = 22,
   parameter int                    ADDR_WIDTH = 5,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   tag_array_arb_if.slave        bus,
   output logic                  sram_csb_o,
   output logic                  sram_web_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_din_o,
   input  logic [DATA_WIDTH-1:0] sram_dout_i
);
   localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
   typedef enum logic [1:0] {RESET_HOLD, INIT, RUN} state_t;
   state_t                state_q;
   logic [ADDR_WIDTH:0]   cnt_q;
   logic                  ptr_q, ptr_d;
   logic                  a_rv_q, b_rv_q;
   logic                  run, init_wr, a_gnt, b_gnt;
   // Grants only in RUN; under contention the pointer favours the side not served last (0 = A)
   always_comb begin
      run     = (state_q == RUN) && !rst;
      init_wr = (state_q == INIT) && !rst;
      a_gnt   = run && bus.a_req && (!bus.b_req || !ptr_q);
      b_gnt   = run && bus.b_req && (!bus.a_req || ptr_q);
      ptr_d   = a_gnt ? 1'b1 : (b_gnt ? 1'b0 : ptr_q);
   end
   // Macro port mux: init sweep write, else the granted port, else idle with csb high
   always_comb begin
      sram_csb_o  = !(init_wr || a_gnt || b_gnt);
      sram_web_o  = init_wr ? 1'b0 : (a_gnt ? !bus.a_we : (b_gnt ? !bus.b_we : 1'b1));
      sram_addr_o = init_wr ? cnt_q[ADDR_WIDTH-1:0] : (a_gnt ? bus.a_addr : (b_gnt ? bus.b_addr : '0));
      sram_din_o  = init_wr ? INIT_VALUE : (a_gnt ? bus.a_wdata : (b_gnt ? bus.b_wdata : '0));
   end
   assign bus.ready    = run;
   assign bus.a_gnt    = a_gnt;
   assign bus.b_gnt    = b_gnt;
   assign bus.a_rvalid = a_rv_q && !rst;
   assign bus.b_rvalid = b_rv_q && !rst;
   assign bus.a_rdata  = sram_dout_i;
   assign bus.b_rdata  = sram_dout_i;
   // Controller state, sweep counter, priority pointer and read-valid pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_HOLD;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         a_rv_q  <= 1'b0;
         b_rv_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         a_rv_q <= a_gnt && !bus.a_we;
         b_rv_q <= b_gnt && !bus.b_we;
         case (state_q)
`ifdef TAG_ARB_INIT_SWEEP_EN
            RESET_HOLD: state_q <= INIT;
`else
            RESET_HOLD: state_q <= RUN;
`endif
            INIT: begin
               cnt_q   <= cnt_q + (ADDR_WIDTH+1)'(1);
               state_q <= (cnt_q == LAST) ? RUN : INIT;
            end
            default: state_q <= state_q;
         endcase
      end
   end
endmodule

// File: tb/tb_tag_array_arb.sv
// tb_tag_array_arb: directed table-driven bench for tag_array_arb with a behavioural SRAM macro model
module tb_tag_array_arb;
   localparam int DW = 22;
   localparam int AW = 5;
   localparam logic [DW-1:0] INIT_V = '0;
`ifdef TAG_ARB_INIT_SWEEP_EN
   localparam int EXP_LAT = 33;
   localparam int EXP_WRITES = 32;
`else
   localparam int EXP_LAT = 1;
   localparam int EXP_WRITES = 0;
`endif
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sram_csb, sram_web;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;
   int            n_chk = 0;
   int            n_pass = 0;
   tag_array_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   tag_array_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT_V)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_addr_o(sram_addr),
      .sram_din_o(sram_din), .sram_dout_i(sram_dout)
   );
   always #5 clk = ~clk;
   // SRAM macro model: inputs registered on posedge, write or read performed on the following negedge
   logic [DW-1:0] mem [32];
   logic          l_csb, l_web;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_din;
   initial for (int i = 0; i < 32; i++) mem[i] <= 22'h155555 ^ DW'(i);
   always @(posedge clk) begin
      l_csb  <= sram_csb;
      l_web  <= sram_web;
      l_addr <= sram_addr;
      l_din  <= sram_din;
   end
   always @(negedge clk) begin
      if (l_csb === 1'b0) begin
         if (!l_web) mem[l_addr] <= l_din;
         else sram_dout <= mem[l_addr];
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   // Drops rst and watches the sweep until ready, checking latency, write count/order and no early grant
   task automatic release_and_sweep(input string tag);
      int  lat;
      int  w;
      bit  order_ok;
      bit  early_gnt;
      lat = -1;
      w = 0;
      order_ok = 1'b1;
      early_gnt = 1'b0;
      rst = 1'b0;
      for (int t = 0; t < 100 && lat < 0; t++) begin
         @(negedge clk); #1;
         if (bus.ready) lat = t;
         else begin
            if (bus.a_gnt || bus.b_gnt) early_gnt = 1'b1;
            if (!sram_csb) begin
               if (sram_web || sram_addr != AW'(w) || sram_din != INIT_V) order_ok = 1'b0;
               w++;
            end
         end
      end
      chk({tag, " ready latency"}, 32'(lat), 32'(EXP_LAT));
      chk({tag, " init writes"}, 32'(w), 32'(EXP_WRITES));
      chk({tag, " init order"}, 32'(order_ok), 32'd1);
      chk({tag, " no gnt before ready"}, 32'(early_gnt), 32'd0);
   endtask
   typedef struct {
      logic          a_req, a_we;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_wd;
      logic          b_req, b_we;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_wd;
      logic          e_ag, e_bg, e_arv, e_brv;
      logic [DW-1:0] e_rd;
      logic          e_csb, e_web;
      logic [AW-1:0] e_addr;
   } vec_t;
   vec_t tbl [18];
   initial begin
      tbl[0]  = '{1'b1,1'b1,5'd3,22'h111,    1'b1,1'b1,5'd5,22'h222,    1'b1,1'b0,1'b0,1'b0,22'h0,      1'b0,1'b0,5'd3};
      tbl[1]  = '{1'b0,1'b0,5'd0,22'h0,      1'b1,1'b1,5'd5,22'h222,    1'b0,1'b1,1'b0,1'b0,22'h0,      1'b0,1'b0,5'd5};
      tbl[2]  = '{1'b1,1'b0,5'd3,22'h0,      1'b1,1'b0,5'd5,22'h0,      1'b1,1'b0,1'b0,1'b0,22'h0,      1'b0,1'b1,5'd3};
      tbl[3]  = '{1'b1,1'b0,5'd3,22'h0,      1'b1,1'b0,5'd5,22'h0,      1'b0,1'b1,1'b1,1'b0,22'h111,    1'b0,1'b1,5'd5};
      tbl[4]  = '{1'b1,1'b0,5'd3,22'h0,      1'b1,1'b0,5'd5,22'h0,      1'b1,1'b0,1'b0,1'b1,22'h222,    1'b0,1'b1,5'd3};
      tbl[5]  = '{1'b1,1'b0,5'd3,22'h0,      1'b1,1'b0,5'd5,22'h0,      1'b0,1'b1,1'b1,1'b0,22'h111,    1'b0,1'b1,5'd5};
      tbl[6]  = '{1'b0,1'b0,5'd0,22'h0,      1'b1,1'b1,5'd9,22'h2ABCDE, 1'b0,1'b1,1'b0,1'b1,22'h222,    1'b0,1'b0,5'd9};
      tbl[7]  = '{1'b1,1'b0,5'd9,22'h0,      1'b0,1'b0,5'd0,22'h0,      1'b1,1'b0,1'b0,1'b0,22'h0,      1'b0,1'b1,5'd9};
      tbl[8]  = '{1'b0,1'b0,5'd0,22'h0,      1'b0,1'b0,5'd0,22'h0,      1'b0,1'b0,1'b1,1'b0,22'h2ABCDE, 1'b1,1'b1,5'd0};
      for (int i = 9; i < 13; i++)
         tbl[i] = '{1'b0,1'b0,5'd0,22'h0,    1'b0,1'b0,5'd0,22'h0,      1'b0,1'b0,1'b0,1'b0,22'h0,      1'b1,1'b1,5'd0};
      tbl[13] = '{1'b1,1'b1,5'd0,22'h3FFFFF, 1'b1,1'b1,5'd1,22'h00ABC,  1'b0,1'b1,1'b0,1'b0,22'h0,      1'b0,1'b0,5'd1};
      tbl[14] = '{1'b1,1'b1,5'd0,22'h3FFFFF, 1'b0,1'b0,5'd0,22'h0,      1'b1,1'b0,1'b0,1'b0,22'h0,      1'b0,1'b0,5'd0};
      tbl[15] = '{1'b1,1'b0,5'd1,22'h0,      1'b1,1'b0,5'd0,22'h0,      1'b0,1'b1,1'b0,1'b0,22'h0,      1'b0,1'b1,5'd0};
      tbl[16] = '{1'b1,1'b0,5'd1,22'h0,      1'b0,1'b0,5'd0,22'h0,      1'b1,1'b0,1'b0,1'b1,22'h3FFFFF, 1'b0,1'b1,5'd1};
      tbl[17] = '{1'b0,1'b0,5'd0,22'h0,      1'b0,1'b0,5'd0,22'h0,      1'b0,1'b0,1'b1,1'b0,22'h00ABC,  1'b1,1'b1,5'd0};
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd17; bus.a_wdata = '0;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 5'd4;  bus.b_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst ready", 32'(bus.ready), 32'd0);
      chk("rst a_gnt", 32'(bus.a_gnt), 32'd0);
      chk("rst b_gnt", 32'(bus.b_gnt), 32'd0);
      chk("rst rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
      chk("rst csb", 32'(sram_csb), 32'd1);
      chk("rst web", 32'(sram_web), 32'd1);
      @(posedge clk); #1;
      bus.b_req = 1'b0;
      release_and_sweep("rel1");
      chk("first a_gnt", 32'(bus.a_gnt), 32'd1);
      chk("first addr", 32'(sram_addr), 32'd17);
      chk("first web", 32'(sram_web), 32'd1);
      @(posedge clk); #1;
      bus.a_req = 1'b0;
      @(negedge clk); #1;
      chk("first a_rvalid", 32'(bus.a_rvalid), 32'd1);
      chk("first b_rvalid", 32'(bus.b_rvalid), 32'd0);
`ifdef TAG_ARB_INIT_SWEEP_EN
      chk("first a_rdata", 32'(bus.a_rdata), 32'(INIT_V));
`endif
      @(posedge clk); #1;
      bus.a_req = 1'b1;
      @(negedge clk); #1;
      chk("midrst a_gnt", 32'(bus.a_gnt), 32'd1);
      @(posedge clk); #1;
      bus.a_req = 1'b0;
      rst = 1'b1;
      @(negedge clk); #1;
      chk("midrst a_rvalid", 32'(bus.a_rvalid), 32'd0);
      chk("midrst ready", 32'(bus.ready), 32'd0);
      chk("midrst csb", 32'(sram_csb), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      release_and_sweep("rel2");
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         bus.a_req = tbl[i].a_req; bus.a_we = tbl[i].a_we; bus.a_addr = tbl[i].a_addr; bus.a_wdata = tbl[i].a_wd;
         bus.b_req = tbl[i].b_req; bus.b_we = tbl[i].b_we; bus.b_addr = tbl[i].b_addr; bus.b_wdata = tbl[i].b_wd;
         @(negedge clk); #1;
         chk($sformatf("r%0d a_gnt", i), 32'(bus.a_gnt), 32'(tbl[i].e_ag));
         chk($sformatf("r%0d b_gnt", i), 32'(bus.b_gnt), 32'(tbl[i].e_bg));
         chk($sformatf("r%0d a_rvalid", i), 32'(bus.a_rvalid), 32'(tbl[i].e_arv));
         chk($sformatf("r%0d b_rvalid", i), 32'(bus.b_rvalid), 32'(tbl[i].e_brv));
         chk($sformatf("r%0d csb", i), 32'(sram_csb), 32'(tbl[i].e_csb));
         if (!tbl[i].e_csb) begin
            chk($sformatf("r%0d web", i), 32'(sram_web), 32'(tbl[i].e_web));
            chk($sformatf("r%0d addr", i), 32'(sram_addr), 32'(tbl[i].e_addr));
         end
         if (tbl[i].e_arv) chk($sformatf("r%0d a_rdata", i), 32'(bus.a_rdata), 32'(tbl[i].e_rd));
         if (tbl[i].e_brv) chk($sformatf("r%0d b_rdata", i), 32'(bus.b_rdata), 32'(tbl[i].e_rd));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
